// File: rtl/my_package.sv
// Shared types for the common data bus: ROB tag width, broadcast record and a tag compare helper.
package my_package;

  localparam int ROB_WIDTH = 6;

  typedef struct packed {
    logic                 valid;
    logic [ROB_WIDTH-1:0] tag;
    logic [31:0]          data;
  } cdb_t;

  function automatic logic tag_match(input logic [ROB_WIDTH-1:0] a,
                                     input logic [ROB_WIDTH-1:0] b);
    return a == b;
  endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick.sv
// rr_pick: combinational wrap-around scan; picks the first set request at or above start.
module rr_pick #(
  parameter  int N_REQ = 4,
  localparam int IW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    start,
  output logic [N_REQ-1:0] grant,
  output logic [IW-1:0]    idx
);

  int   j;
  logic found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int off = 0; off < N_REQ; off++) begin
      j = (int'(start) + off) % N_REQ;
      if (!found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = IW'(j);
      end
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: grants one result producer per cycle onto a registered common data bus.
// Define CDB_ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise lowest index wins.
module cdb_arbiter
  import my_package::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int ROB_WIDTH = my_package::ROB_WIDTH,
  localparam int IW        = $clog2(N_REQ)
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            flush,
  input  logic [N_REQ-1:0]                req_valid,
  input  logic [N_REQ-1:0][ROB_WIDTH-1:0] req_tag,
  input  logic [N_REQ-1:0][31:0]          req_data,
  output logic [N_REQ-1:0]                req_ready,
  output cdb_t                            cdb,
  output logic [IW-1:0]                   grant_idx
);

  logic [N_REQ-1:0] valid_eff;
  logic [N_REQ-1:0] pick_grant;
  logic [IW-1:0]    pick_idx;
  logic [IW-1:0]    start;
  logic             any_grant;

  cdb_t             cdb_q, cdb_d;
  logic [IW-1:0]    grant_idx_q, grant_idx_d;

  // Reset and flush both mask every request, so nothing is granted or consumed.
  assign valid_eff = (rstn && !flush) ? req_valid : '0;
  assign any_grant = |pick_grant;
  assign req_ready = pick_grant;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req   (valid_eff),
    .start (start),
    .grant (pick_grant),
    .idx   (pick_idx)
  );

`ifdef CDB_ARB_ROUND_ROBIN_EN
  logic [IW-1:0] ptr_q, ptr_d;

  assign start = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (any_grant) begin
      ptr_d = (pick_idx == IW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign start = '0;
`endif

  // Tag, data and index hold through idle cycles; only valid drops.
  always_comb begin
    cdb_d       = cdb_q;
    grant_idx_d = grant_idx_q;
    cdb_d.valid = any_grant;
    if (any_grant) begin
      cdb_d.tag   = req_tag[pick_idx];
      cdb_d.data  = req_data[pick_idx];
      grant_idx_d = pick_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cdb_q       <= '0;
      grant_idx_q <= '0;
    end else begin
      cdb_q       <= cdb_d;
      grant_idx_q <= grant_idx_d;
    end
  end

  assign cdb       = cdb_q;
  assign grant_idx = grant_idx_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: expected broadcasts are queued by the driver and checked by a monitor.
module tb_cdb_arbiter;
  import my_package::*;

  localparam int N  = 4;
  localparam int RW = my_package::ROB_WIDTH;
  localparam int EW = 1 + 1 + 2 + RW + 32;

  logic                   clk;
  logic                   rstn;
  logic                   flush;
  logic [N-1:0]           req_valid;
  logic [N-1:0][RW-1:0]   req_tag;
  logic [N-1:0][31:0]     req_data;
  logic [N-1:0]           req_ready;
  cdb_t                   cdb;
  logic [1:0]             grant_idx;

  cdb_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .flush     (flush),
    .req_valid (req_valid),
    .req_tag   (req_tag),
    .req_data  (req_data),
    .req_ready (req_ready),
    .cdb       (cdb),
    .grant_idx (grant_idx)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  int vec_no = 0;

  // entry = {chk_idx, valid, idx, tag, data}
  logic [EW-1:0] exp_q[$];
  logic [RW-1:0] held_tag;
  logic [31:0]   held_data;
  logic [1:0]    held_idx;

  // driver: apply one cycle of inputs; g is the hand-computed grant (-1 = none)
  task automatic vec(input logic r, input logic f, input logic [N-1:0] v, input int g);
    logic [N-1:0] exp_ready;
    logic         chk_idx;
    logic         ev;
    @(negedge clk);
    rstn      = r;
    flush     = f;
    req_valid = v;
    vec_no++;
    #1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    checks++;
    if (req_ready !== exp_ready) begin
      errors++;
      $display("FAIL ready v%0d got %b want %b", vec_no, req_ready, exp_ready);
    end
    chk_idx = 1'b0;
    ev      = 1'b0;
    if (!r) begin
      held_tag  = '0;
      held_data = '0;
      held_idx  = '0;
      chk_idx   = 1'b1;
    end else if (g >= 0) begin
      held_tag  = req_tag[g];
      held_data = req_data[g];
      held_idx  = 2'(g);
      chk_idx   = 1'b1;
      ev        = 1'b1;
    end
    exp_q.push_back({chk_idx, ev, held_idx, held_tag, held_data});
  endtask

  // scoreboard monitor: compares each registered broadcast against the queue head
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (cdb.valid !== e[EW-2] || cdb.tag !== e[32 +: RW] || cdb.data !== e[31:0] ||
            (e[EW-1] && grant_idx !== e[RW+32 +: 2])) begin
          errors++;
          $display("FAIL cdb got v=%b tag=%0d data=%h idx=%0d want v=%b tag=%0d data=%h idx=%0d(chk=%b)",
                   cdb.valid, cdb.tag, cdb.data, grant_idx,
                   e[EW-2], e[32 +: RW], e[31:0], e[RW+32 +: 2], e[EW-1]);
        end
      end
    end
  end

  initial begin
    int wait_cyc;
    rstn      = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    held_tag  = '0;
    held_data = '0;
    held_idx  = '0;
    for (int i = 0; i < N; i++) begin
      req_tag[i]  = RW'(i + 3);
      req_data[i] = 32'hDEADBEED + 32'(i);
    end

    // reset with every requester pending
    vec(1'b0, 1'b0, 4'b1111, -1);
    vec(1'b0, 1'b0, 4'b1111, -1);
    // single request, then idle hold, then wrap from ptr=3
    vec(1'b1, 1'b0, 4'b0100, 2);
    vec(1'b1, 1'b0, 4'b0000, -1);
    vec(1'b1, 1'b0, 4'b0001, 0);
    // back-to-back stream from a fresh reset
    vec(1'b0, 1'b0, 4'b0000, -1);
`ifdef CDB_ARB_ROUND_ROBIN_EN
    vec(1'b1, 1'b0, 4'b1111, 0);
    vec(1'b1, 1'b0, 4'b1111, 1);
    vec(1'b1, 1'b0, 4'b1111, 2);
    vec(1'b1, 1'b0, 4'b1111, 3);
    vec(1'b1, 1'b0, 4'b1111, 0);
    vec(1'b1, 1'b0, 4'b1010, 1);
    vec(1'b1, 1'b1, 4'b0011, -1);
    vec(1'b1, 1'b0, 4'b1011, 3);
    vec(1'b0, 1'b0, 4'b1111, -1);
    vec(1'b1, 1'b0, 4'b1111, 0);
    vec(1'b1, 1'b0, 4'b0110, 1);
    vec(1'b1, 1'b0, 4'b1100, 2);
    vec(1'b1, 1'b0, 4'b1001, 3);
`else
    vec(1'b1, 1'b0, 4'b1111, 0);
    vec(1'b1, 1'b0, 4'b1111, 0);
    vec(1'b1, 1'b0, 4'b1111, 0);
    vec(1'b1, 1'b0, 4'b1111, 0);
    vec(1'b1, 1'b0, 4'b1111, 0);
    vec(1'b1, 1'b0, 4'b1010, 1);
    vec(1'b1, 1'b1, 4'b0011, -1);
    vec(1'b1, 1'b0, 4'b1011, 0);
    vec(1'b0, 1'b0, 4'b1111, -1);
    vec(1'b1, 1'b0, 4'b1111, 0);
    vec(1'b1, 1'b0, 4'b0110, 1);
    vec(1'b1, 1'b0, 4'b1100, 2);
    vec(1'b1, 1'b0, 4'b1001, 0);
`endif
    vec(1'b1, 1'b0, 4'b0000, -1);

    // drain the scoreboard with a bounded wait
    wait_cyc = 0;
    while (exp_q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    #3;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
